// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request fields are held stable by the master until memAck or abandonment.
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [3:0]            memWe;
  logic [31:0]           memWdata;
  logic [31:0]           memRdata;
  logic                  memAck;

  modport master (
    output memReq, memAddr, memWe, memWdata,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memAddr, memWe, memWdata,
    output memRdata, memAck
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data-memory access with timeout, load alignment/extension.
// Optional macro MEM_ALIGN_CHECK_EN adds misaligned-access rejection and the alignError output.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic [4:0]  writeRegister,
  input  logic [31:0] writeData,
  input  logic [31:0] aluOut,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic [3:0]  memWrite,
  input  logic [1:0]  memReadWidth,
  input  logic        loadUnsigned,
  output logic        stall,
  mem_access_stage_if.master mem,
  output logic        outValid,
  output logic [4:0]  writeRegisterOut,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic [31:0] aluOutOut,
  output logic [31:0] readDataOut,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        alignError,
`endif
  output logic        busError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t      r_state;
  logic [CW-1:0] r_count;
  logic [31:0] r_alu;
  logic [4:0]  r_wreg;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic [1:0]  r_width;
  logic        r_unsigned;

  logic w_isMem;
  logic w_misalign;
  logic w_timeout;

  function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] width,
                                             input logic [1:0] a, input logic uns);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? rdata[31:16] : rdata[15:0];
    b = rdata[{a, 3'b000} +: 8];
    case (width)
      2'b01:   align_load = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   align_load = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default: align_load = rdata;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Reserved width 2'b11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] a,
                                      input logic [3:0] we);
    logic [3:0] lanes;
    logic       bad;
    case (width)
      2'b01:   begin lanes = a[1] ? 4'b1100 : 4'b0011; bad = a[0];        end
      2'b10:   begin lanes = 4'b0001 << a;             bad = 1'b0;        end
      default: begin lanes = 4'b1111;                  bad = (a != 2'b00); end
    endcase
    misaligned = bad | ((we != 4'b0000) && (we != lanes));
  endfunction

  assign w_misalign = misaligned(memReadWidth, aluOut[1:0], memWrite);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_isMem   = inValid & (memToReg | (memWrite != 4'b0000));
  assign w_timeout = (r_state == BUSY) && !mem.memAck && (r_count == CW'(TIMEOUT_CYCLES - 1));
  assign stall     = ((r_state == IDLE) && w_isMem && !w_misalign) ||
                     ((r_state == BUSY) && !mem.memAck && !w_timeout);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_alu            <= '0;
      r_wreg           <= '0;
      r_regwrite       <= 1'b0;
      r_memtoreg       <= 1'b0;
      r_width          <= '0;
      r_unsigned       <= 1'b0;
      mem.memReq       <= 1'b0;
      mem.memAddr      <= '0;
      mem.memWe        <= '0;
      mem.memWdata     <= '0;
      outValid         <= 1'b0;
      writeRegisterOut <= '0;
      regWriteOut      <= 1'b0;
      memToRegOut      <= 1'b0;
      aluOutOut        <= '0;
      readDataOut      <= '0;
      busError         <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      alignError       <= 1'b0;
`endif
    end else begin
      busError <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      alignError <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_isMem && !w_misalign) begin
            r_alu        <= aluOut;
            r_wreg       <= writeRegister;
            r_regwrite   <= regWrite;
            r_memtoreg   <= memToReg;
            r_width      <= memReadWidth;
            r_unsigned   <= loadUnsigned;
            mem.memReq   <= 1'b1;
            mem.memAddr  <= ADDR_WIDTH'(aluOut);
            mem.memWe    <= memWrite;
            mem.memWdata <= writeData;
            r_count      <= '0;
            outValid     <= 1'b0;
            r_state      <= BUSY;
          end else begin
            outValid         <= inValid;
            writeRegisterOut <= writeRegister;
            regWriteOut      <= regWrite;
            memToRegOut      <= memToReg;
            aluOutOut        <= aluOut;
            readDataOut      <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            if (w_isMem) begin
              alignError  <= 1'b1;
              outValid    <= 1'b1;
              regWriteOut <= 1'b0;
            end
`endif
          end
        end
        BUSY: begin
          if (mem.memAck || w_timeout) begin
            mem.memReq       <= 1'b0;
            r_state          <= IDLE;
            outValid         <= 1'b1;
            writeRegisterOut <= r_wreg;
            memToRegOut      <= r_memtoreg;
            aluOutOut        <= r_alu;
            // A store (even when also flagged as a load) never returns read data.
            if (mem.memAck) begin
              regWriteOut <= r_regwrite;
              readDataOut <= (r_memtoreg && mem.memWe == 4'b0000) ?
                             align_load(mem.memRdata, r_width, r_alu[1:0], r_unsigned) : 32'h0;
            end else begin
              regWriteOut <= 1'b0;
              readDataOut <= '0;
              busError    <= 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage; sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Performs loads and stores against an external data memory through a req/ack handshake that may insert wait states.
- Stalls upstream while a transaction is pending.
- Aligns and extends load data, then registers results for writeback.

Parameters:
- TIMEOUT_CYCLES, 16, max BUSY cycles without memAck before the access is abandoned.
- ADDR_WIDTH, 32, width of memAddr.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising clock edge
- inValid  in  1  EX/MEM slot holds a live instruction
- writeRegister  in  5  destination register
- writeData  in  32  store data, already lane-positioned
- aluOut  in  32  effective address / ALU result
- regWrite  in  1  writeback enable
- memToReg  in  1  instruction is a load
- memWrite  in  4  store byte enables (nonzero = store)
- memReadWidth  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- loadUnsigned  in  1  zero-extend (1) / sign-extend (0) sub-word loads
- stall  out  1  hold upstream stages this cycle
- memReq  out  1  memory request
- memAddr  out  ADDR_WIDTH  byte address
- memWe  out  4  byte write enables (0 = read)
- memWdata  out  32  store data
- memRdata  in  32  read data, valid with memAck
- memAck  in  1  transaction complete
- outValid  out  1  MEM/WB slot valid
- writeRegisterOut  out  5  destination register
- regWriteOut  out  1  writeback enable
- memToRegOut  out  1  load flag
- aluOutOut  out  32  ALU result
- readDataOut  out  32  aligned, extended load data
- busError  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; all outputs 0; timeout counter 0.
  - Reset mid-transaction drops memReq the next cycle with no output update.
- isMem = inValid & (memToReg | memWrite!=0).
- stall (combinational) = (IDLE & isMem) | (BUSY & !memAck & !timeout).
- IDLE, !isMem:
  - Next edge registers the pass-through fields into the outputs.
  - outValid <= inValid; readDataOut <= 0.
- IDLE, isMem:
  - Latch address, memWrite, writeData, width, loadUnsigned, writeRegister, regWrite, memToReg.
  - Go to BUSY. memReq, memAddr, memWe and memWdata are registered: they assert the cycle after, and stay stable through BUSY.
  - outValid <= 0.
- BUSY, memAck:
  - Next edge: memReq <= 0; state <= IDLE; latched fields go to the outputs; outValid <= 1.
  - Loads: readDataOut <= aligned memRdata.
  - stall is already 0 in the ack cycle, so upstream advances on that same edge.
- BUSY, no ack:
  - Counter increments each cycle. The count of TIMEOUT_CYCLES includes the first BUSY cycle.
  - On reaching TIMEOUT_CYCLES: busError pulses 1 cycle; memReq <= 0; state <= IDLE.
  - outValid <= 1 with regWriteOut forced 0 and readDataOut = 0. stall is 0 in that cycle.
  - Counter clears on entry to BUSY.
- memAck while IDLE is ignored.
- Load alignment (little-endian), with a = address[1:0]:
  - word: memRdata.
  - half: a[1] ? memRdata[31:16] : memRdata[15:0].
  - byte: memRdata[8a+7:8a].
  - Extension to 32 bits per loadUnsigned.
- Stores: memWe = latched memWrite; memWdata = latched writeData, unmodified. readDataOut = 0.
- Load and store together (memToReg=1 and memWrite!=0): store takes priority and memWe is nonzero. readDataOut = 0.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - adds output alignError (1 bit).
  - Misaligned access in IDLE issues no memReq and does not enter BUSY. Misaligned means:
    - word with address[1:0]!=0, or
    - half with address[0]!=0, or
    - store whose memWrite lanes disagree with the width/offset.
  - stall = 0 in that cycle.
  - Next edge: alignError pulses 1 cycle; outValid <= 1 with regWriteOut 0.
- Undefined:
  - no alignError port.
  - word ignores address[1:0]; half ignores address[0]; store lanes are taken as given.

Test Plan:
- Reset held low 2 cycles mid-BUSY -> memReq 0, all outputs 0, state IDLE. Release -> non-mem op aluOut=0x1234 passes through next edge with outValid=1.
- Byte load, aluOut=0x103, loadUnsigned=0, memRdata=0x80FF_0000, ack after 3 wait cycles:
  - stall high for IDLE cycle + 3 BUSY cycles, low in ack cycle.
  - readDataOut=0xFFFF_FF80.
  - memAddr=0x103, memWe=0.
- Half load, aluOut=0x202, loadUnsigned=1, memRdata=0xBEEF_1234, immediate ack -> readDataOut=0x0000_BEEF, outValid 1 one cycle later.
- Store, memWrite=4'b1100, writeData=0xAABB_0000, aluOut=0x40 -> memReq with memWe=1100, memWdata=0xAABB_0000. After ack, regWriteOut=0 and readDataOut=0.
- No ack for 16 BUSY cycles (TIMEOUT_CYCLES=16) -> busError single pulse; memReq drops; regWriteOut=0; stall released; next queued op proceeds.
- With MEM_ALIGN_CHECK_EN, word load at aluOut=0x102 -> no memReq, alignError pulse, regWriteOut=0, stall 0 throughout.
